// File: rtl/bcd_scan_counter_pkg.sv
// Shared BCD digit types and single-digit step arithmetic for the scan counter
// and any later BCD stages.
package bcd_scan_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Returns {next_digit, cout}; with cin=0 the digit passes through unchanged.
  function automatic logic [BCD_W:0] bcd_step(input bcd_digit_t digit, input logic up,
                                              input logic cin);
    logic [BCD_W:0] res;
    res = {digit, 1'b0};
    if (cin) begin
      if (up) begin
        res = (digit >= BCD_MAX) ? {4'd0, 1'b1} : {digit + 4'd1, 1'b0};
      end else begin
        res = (digit == 4'd0) ? {BCD_MAX, 1'b1} : {digit - 4'd1, 1'b0};
      end
    end
    return res;
  endfunction

  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? 4'd0 : digit;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_digit_cell.sv
// One BCD digit register with clear/load/step; carry or borrow out is combinational
// so a chain of cells ripples within one cycle.
module bcd_digit_cell
  import bcd_scan_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       cin,
  input  logic       up,
  output logic [3:0] digit,
  output logic       cout
);

  bcd_digit_t     r_digit;
  logic [BCD_W:0] w_step;

  assign w_step = bcd_step(r_digit, up, cin);
  assign cout   = w_step[0];
  assign digit  = r_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (load) begin
      r_digit <= bcd_sanitize(load_digit);
    end else if (cin) begin
      r_digit <= w_step[BCD_W:1];
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a registered, time-multiplexed digit scan
// feeding a 7-segment decoder and the digit common lines.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int SCAN_W     = $clog2(SCAN_DIV)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    tick,
  input  logic                    up,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] w_count;
  logic                    w_carry_out;

  // Per-digit carry nets live inside each generate block so the ripple chain
  // is a sequence of distinct scalars rather than one self-referencing vector.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic w_cin;
      logic w_cout;
      if (gi == 0) begin : g_first
        assign w_cin = tick;
      end else begin : g_chain
        assign w_cin = g_digit[gi-1].w_cout;
      end
      bcd_digit_cell u_cell (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load       (load),
        .load_digit (load_val[gi*4 +: 4]),
        .cin        (w_cin),
        .up         (up),
        .digit      (w_count[gi*4 +: 4]),
        .cout       (w_cout)
      );
    end
  endgenerate

  assign w_carry_out = g_digit[NUM_DIGITS-1].w_cout;
  assign count       = w_count;

  logic r_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= ~clr & ~load & w_carry_out;
    end
  end

  assign wrap = r_wrap;

  logic [SCAN_W-1:0]     r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_bcd;
  logic [NUM_DIGITS-1:0] r_sel_n;
  logic                  w_presc_last;
  logic [IDX_W-1:0]      w_idx_next;

  assign w_presc_last = (r_presc == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    w_idx_next = r_idx;
    if (w_presc_last) begin
      w_idx_next = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Select and nibble both come from the next index, so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_bcd   <= 4'h0;
      r_sel_n <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      r_presc <= w_presc_last ? '0 : r_presc + SCAN_W'(1);
      r_idx   <= w_idx_next;
      r_bcd   <= w_count[{w_idx_next, 2'b00} +: 4];
      r_sel_n <= ~(NUM_DIGITS'(1) << w_idx_next);
    end
  end

  assign bcd_out     = r_bcd;
  assign digit_sel_n = r_sel_n;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomised and directed check of bcd_scan_counter against a decimal-integer
// model of the count and a slot-number model of the scan.
module tb_bcd_scan_counter;

  localparam int ND  = 4;
  localparam int SD  = 4;
  localparam int MOD = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   load_val = '0;
  logic          tick = 1'b0;
  logic          up = 1'b0;
  logic [3:0]    bcd_out;
  logic [ND-1:0] digit_sel_n;
  logic [15:0]   count;
  logic          wrap;

  bcd_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .load        (load),
    .load_val    (load_val),
    .tick        (tick),
    .up          (up),
    .bcd_out     (bcd_out),
    .digit_sel_n (digit_sel_n),
    .count       (count),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_v = 0;
  int wraps_dut = 0;
  int wraps_model = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int digit_of(input int v, input int i);
    int t;
    t = v;
    for (int k = 0; k < i; k++) t = t / 10;
    return t % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  function automatic int load_to_dec(input logic [15:0] lv);
    int v, p;
    logic [3:0] nib;
    v = 0;
    p = 1;
    for (int i = 0; i < ND; i++) begin
      nib = lv[i*4 +: 4];
      if (nib <= 4'd9) v += int'(nib) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic nibbles_ok(input logic [15:0] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < ND; i++) if (c[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic check_reset(input string tag);
    check_val({tag, "_count"}, count, 32'h0);
    check_val({tag, "_wrap"}, wrap, 32'h0);
    check_val({tag, "_sel"}, digit_sel_n, 32'he);
    check_val({tag, "_bcd"}, bcd_out, 32'h0);
  endtask

  // One clock transaction: drive, advance the model, compare after the edge.
  task automatic step(input logic c, input logic l, input logic [15:0] lv,
                      input logic t, input logic u);
    int prev, nv, idx;
    logic ew;
    logic [ND-1:0] es;
    clr = c; load = l; load_val = lv; tick = t; up = u;
    prev = model_v;
    ew = 1'b0;
    if (c) nv = 0;
    else if (l) nv = load_to_dec(lv);
    else if (t && u) begin ew = (prev == MOD - 1); nv = (prev + 1) % MOD; end
    else if (t) begin ew = (prev == 0); nv = (prev + MOD - 1) % MOD; end
    else nv = prev;
    @(posedge clk);
    #1;
    cyc++;
    model_v = nv;
    if (ew) wraps_model++;
    if (wrap) wraps_dut++;
    idx = (cyc / SD) % ND;
    es = '1;
    es[idx] = 1'b0;
    $display("cyc=%0d clr=%b load=%b val=%h tick=%b up=%b count=%h wrap=%b sel=%b bcd=%h",
             cyc, c, l, lv, t, u, count, wrap, digit_sel_n, bcd_out);
    check_val("count", count, to_bcd(nv));
    check_val("wrap", wrap, ew);
    check_val("sel_n", digit_sel_n, es);
    check_val("bcd_out", bcd_out, digit_of(prev, idx));
    check_val("nibbles", nibbles_ok(count), 1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    model_v = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(posedge clk);
    release_reset();
    idle(16);

    step(1'b0, 1'b1, 16'h0999, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    idle(16);

    step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    idle(1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(1);

    step(1'b0, 1'b1, 16'h3A7F, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'hFB2C, 1'b0, 1'b0);

    // Asynchronous reset partway through a slot while count = 1234.
    step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    idle(2);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    release_reset();
    idle(8);

    // Asynchronous reset while wrap is pulsing.
    step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("wrap_rst");
    release_reset();
    idle(4);

    for (int i = 0; i < 10000; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check_val("wrap_total", wraps_dut, wraps_model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
